alu_flag_unit: RTL and testbench

Registered status-flag stage directly downstream of the ALU overflow select. It samples the selected overflow bit together with the ALU result and carry, and holds the V/C/Z/N flags. It also keeps a sticky overflow bit and a saturating overflow counter. It raises an overflow interrupt to the controller using a four-phase request/acknowledge handshake.

---
 rtl/alu_flag_unit_pkg.sv | 24 ++
 rtl/alu_irq_handshake.sv | 53 +++++
 rtl/alu_flag_unit.sv | 69 ++++++
 tb/tb_alu_flag_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_flag_unit_pkg.sv
// Shared ALU definitions: opcode constants, flag bit positions and the
// overflow interrupt handshake state encoding.
package alu_flag_unit_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        ACKED = 2'b10
    } irq_state_e;

    // Only add and subtract produce meaningful V and C.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_irq_handshake.sv
// Four-phase overflow interrupt handshake with a single merged pending event.
module alu_irq_handshake
    import alu_flag_unit_pkg::*;
(
    input  logic Clk,
    input  logic RstN,
    input  logic Event,
    input  logic IrqEn,
    input  logic IrqAck,
    output logic Irq
);

    irq_state_e state;
    logic       pending;
    logic       req_c;

    assign req_c = Event & IrqEn;

    // Events arriving mid-handshake collapse into one pending request.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state   <= IDLE;
            pending <= 1'b0;
            Irq     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_c || pending) begin
                        state   <= REQ;
                        pending <= 1'b0;
                        Irq     <= 1'b1;
                    end
                end
                REQ: begin
                    if (req_c) pending <= 1'b1;
                    if (IrqAck) begin
                        state <= ACKED;
                        Irq   <= 1'b0;
                    end
                end
                ACKED: begin
                    if (req_c) pending <= 1'b1;
                    if (!IrqAck) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_flag_unit.sv
// Registered V/C/Z/N flag stage with sticky overflow, saturating overflow
// counter and an overflow interrupt request.
module alu_flag_unit
    import alu_flag_unit_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 RstN,
    input  logic                 Valid,
    input  logic [2:0]           Sel,
    input  logic                 OvfIn,
    input  logic                 CarryIn,
    input  logic [WIDTH-1:0]     Result,
    input  logic                 IrqEn,
    input  logic                 IrqAck,
    input  logic                 ClrSticky,
    output logic [3:0]           Flags,
    output logic                 StickyOvf,
    output logic [CNT_WIDTH-1:0] OvfCount,
    output logic                 Irq
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic arith_c;
    logic v_c;
    logic ovf_event_c;

    assign arith_c     = is_arith(Sel);
    assign v_c         = arith_c & OvfIn;
    assign ovf_event_c = Valid & v_c;

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            Flags <= 4'b0000;
        end else if (Valid) begin
            Flags[FLAG_V] <= v_c;
            Flags[FLAG_C] <= arith_c & CarryIn;
            Flags[FLAG_Z] <= (Result == '0);
            Flags[FLAG_N] <= Result[WIDTH-1];
        end
    end

    // Clearing takes priority over a coincident overflow event.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            StickyOvf <= 1'b0;
            OvfCount  <= '0;
        end else if (ClrSticky) begin
            StickyOvf <= 1'b0;
            OvfCount  <= '0;
        end else if (ovf_event_c) begin
            StickyOvf <= 1'b1;
            if (OvfCount != CNT_MAX) OvfCount <= OvfCount + CNT_WIDTH'(1);
        end
    end

    alu_irq_handshake u_irq (
        .Clk    (Clk),
        .RstN   (RstN),
        .Event  (ovf_event_c),
        .IrqEn  (IrqEn),
        .IrqAck (IrqAck),
        .Irq    (Irq)
    );

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_alu_flag_unit;

    logic       Clk = 1'b0;
    logic       RstN;
    logic       Valid;
    logic [2:0] Sel;
    logic       OvfIn;
    logic       CarryIn;
    logic [7:0] Result;
    logic       IrqEn;
    logic       IrqAck;
    logic       ClrSticky;
    logic [3:0] Flags;
    logic       StickyOvf;
    logic [3:0] OvfCount;
    logic       Irq;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    // Behavioural model state.
    logic [3:0] m_flags;
    int         m_cnt;
    bit         m_sticky, m_req, m_wait, m_pend;

    alu_flag_unit #(.WIDTH(8), .CNT_WIDTH(4)) dut (
        .Clk       (Clk),
        .RstN      (RstN),
        .Valid     (Valid),
        .Sel       (Sel),
        .OvfIn     (OvfIn),
        .CarryIn   (CarryIn),
        .Result    (Result),
        .IrqEn     (IrqEn),
        .IrqAck    (IrqAck),
        .ClrSticky (ClrSticky),
        .Flags     (Flags),
        .StickyOvf (StickyOvf),
        .OvfCount  (OvfCount),
        .Irq       (Irq)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the rules to the inputs present at this rising edge.
    task automatic model_update();
        bit arith, v, ev, rq;
        if (!RstN) begin
            m_flags = 4'b0000; m_cnt = 0; m_sticky = 0;
            m_req = 0; m_wait = 0; m_pend = 0;
            return;
        end
        arith = (Sel == 3'd0) || (Sel == 3'd1);
        v     = arith && OvfIn;
        ev    = Valid && v;
        rq    = ev && IrqEn;
        if (Valid) m_flags = {v, arith && CarryIn, Result == 8'd0, Result[7]};
        if (ClrSticky) begin
            m_sticky = 0; m_cnt = 0;
        end else if (ev) begin
            m_sticky = 1;
            m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
        end
        if (m_req) begin
            if (rq) m_pend = 1;
            if (IrqAck) begin m_req = 0; m_wait = 1; end
        end else if (m_wait) begin
            if (rq) m_pend = 1;
            if (!IrqAck) m_wait = 0;
        end else if (rq || m_pend) begin
            m_req = 1; m_pend = 0;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic o,
                         input logic c, input logic [7:0] r);
        Valid = v; Sel = s; OvfIn = o; CarryIn = c; Result = r;
    endtask

    always @(negedge Clk) begin
        if (chk_on) begin
            chk("model_flags",  32'(Flags),     32'(m_flags));
            chk("model_sticky", 32'(StickyOvf), 32'(m_sticky));
            chk("model_count",  32'(OvfCount),  32'(m_cnt));
            chk("model_irq",    32'(Irq),       32'(m_req));
        end
    end

    initial begin
        RstN = 1'b0; IrqEn = 1'b0; IrqAck = 1'b0; ClrSticky = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
        tick(); tick();
        chk_on = 1;
        RstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_flags", 32'(Flags), 32'h0);
            chk("idle_irq", 32'(Irq), 32'h0);
        end
        chk("idle_count", 32'(OvfCount), 32'h0);

        // Add overflow and full handshake.
        IrqEn = 1'b1;
        drive(1'b1, 3'b000, 1'b1, 1'b0, 8'h80);
        tick();
        chk("add_flags", 32'(Flags), 32'b1001);
        chk("add_sticky", 32'(StickyOvf), 32'h1);
        chk("add_count", 32'(OvfCount), 32'h1);
        chk("add_irq", 32'(Irq), 32'h1);
        Valid = 1'b0; IrqAck = 1'b1;
        tick();
        chk("ack_irq_low", 32'(Irq), 32'h0);
        IrqAck = 1'b0;
        tick(); tick();
        chk("release_irq_low", 32'(Irq), 32'h0);

        // Non-arithmetic opcode gates V and C.
        drive(1'b1, 3'b010, 1'b1, 1'b1, 8'h00);
        tick();
        chk("nonarith_flags", 32'(Flags), 32'b0010);
        chk("nonarith_sticky", 32'(StickyOvf), 32'h1);
        chk("nonarith_irq", 32'(Irq), 32'h0);
        Valid = 1'b0;
        tick();

        // Pending merge: one request plus three merged events.
        drive(1'b1, 3'b001, 1'b1, 1'b1, 8'h01);
        tick();
        chk("merge_irq_first", 32'(Irq), 32'h1);
        tick(); tick(); tick();
        chk("merge_count", 32'(OvfCount), 32'd5);
        Valid = 1'b0; IrqAck = 1'b1;
        tick();
        chk("merge_acked_irq", 32'(Irq), 32'h0);
        IrqAck = 1'b0;
        tick();
        chk("merge_gap_irq", 32'(Irq), 32'h0);
        tick();
        chk("merge_second_irq", 32'(Irq), 32'h1);
        IrqAck = 1'b1; tick();
        IrqAck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("merge_no_third", 32'(Irq), 32'h0);
        end

        // Saturation then clear colliding with an event.
        IrqEn = 1'b0;
        drive(1'b1, 3'b000, 1'b1, 1'b0, 8'h7f);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_count", 32'(OvfCount), 32'd15);
        chk("sat_irq", 32'(Irq), 32'h0);
        ClrSticky = 1'b1;
        tick();
        chk("clr_count", 32'(OvfCount), 32'h0);
        chk("clr_sticky", 32'(StickyOvf), 32'h0);
        chk("clr_flag_v", 32'(Flags[3]), 32'h1);
        ClrSticky = 1'b0; Valid = 1'b0;
        tick();

        // Reset during a handshake with a pending event.
        IrqEn = 1'b1;
        drive(1'b1, 3'b000, 1'b1, 1'b0, 8'h10);
        tick(); tick();
        chk("rst_pre_irq", 32'(Irq), 32'h1);
        Valid = 1'b0; RstN = 1'b0;
        tick();
        chk("rst_irq", 32'(Irq), 32'h0);
        RstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_req", 32'(Irq), 32'h0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            RstN      = ($urandom_range(0, 99) != 0);
            Valid     = $urandom_range(0, 3) != 0;
            Sel       = 3'($urandom_range(0, 7));
            OvfIn     = $urandom_range(0, 1) == 1;
            CarryIn   = $urandom_range(0, 1) == 1;
            Result    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            IrqEn     = $urandom_range(0, 3) != 0;
            IrqAck    = $urandom_range(0, 1) == 1;
            ClrSticky = $urandom_range(0, 31) == 0;
            tick();
        end

        @(negedge Clk);
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
